// File: rtl/mem_responder.sv
// Single-port SRAM responder for the core's fetch and data buses, fixed wait states.
// Define MEM_RESP_RANGE_CHECK_EN to suppress and flag accesses beyond 4*MEM_WORDS bytes.
module mem_responder #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_iaddr,
  input  logic [ADDR_W-1:0]            iaddr,
  output logic [31:0]                  idata,
  input  logic                         dbus_re,
  input  logic                         dbus_we,
  input  logic [ADDR_W-1:0]            daddr,
  input  logic [31:0]                  dwdata,
  input  logic [3:0]                   dbe,
  output logic [31:0]                  drdata,
  output logic                         stall,
  output logic                         err,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic                         mem_re,
  output logic                         mem_we,
  output logic [3:0]                   mem_be,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata
);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_data_q, is_data_d;
  logic              is_store_q, is_store_d;
  logic              oor_q, oor_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              i_served_q, i_served_d, d_served_q, d_served_d;
  logic [ADDR_W-1:0] i_srv_addr_q, i_srv_addr_d, d_srv_addr_q, d_srv_addr_d;
  logic [31:0]       idata_q, idata_d, drdata_q, drdata_d;
  logic              mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              d_req, i_keep, d_keep, i_new, d_new, sel_store, sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       rdata_eff;

  // A served flag survives only while the same request is still being held.
  assign d_req     = dbus_re | dbus_we;
  assign i_keep    = i_served_q & en_iaddr & (iaddr == i_srv_addr_q);
  assign d_keep    = d_served_q & d_req & (daddr == d_srv_addr_q);
  assign i_new     = en_iaddr & ~i_keep;
  assign d_new     = d_req & ~d_keep;
  assign sel_addr  = d_new ? daddr : iaddr;
  assign sel_store = d_new & dbus_we;
  assign rdata_eff = oor_q ? 32'd0 : mem_rdata;

`ifdef MEM_RESP_RANGE_CHECK_EN
  assign sel_oor = (sel_addr >> (AW + 2)) != '0;
`else
  assign sel_oor = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_data_d    = is_data_q;
    is_store_d   = is_store_q;
    oor_d        = oor_q;
    addr_d       = addr_q;
    i_served_d   = i_keep;
    d_served_d   = d_keep;
    i_srv_addr_d = i_srv_addr_q;
    d_srv_addr_d = d_srv_addr_q;
    idata_d      = idata_q;
    drdata_d     = drdata_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (i_new | d_new) begin
          is_data_d   = d_new;
          is_store_d  = sel_store;
          oor_d       = sel_oor;
          addr_d      = sel_addr;
          mem_re_d    = ~sel_oor & ~sel_store;
          mem_we_d    = ~sel_oor & sel_store;
          mem_addr_d  = sel_addr[AW+1:2];
          mem_be_d    = dbe;
          mem_wdata_d = dwdata;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (WAIT_STATES == 0) begin
          state_d = StDone;
        end else begin
          cnt_d   = 4'(WAIT_STATES);
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StDone;
      end
      StDone: begin
        if (is_data_q) begin
          d_served_d   = 1'b1;
          d_srv_addr_d = addr_q;
          if (!is_store_q) drdata_d = rdata_eff;
        end else begin
          i_served_d   = 1'b1;
          i_srv_addr_d = addr_q;
          idata_d      = rdata_eff;
        end
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      is_data_q    <= 1'b0;
      is_store_q   <= 1'b0;
      oor_q        <= 1'b0;
      addr_q       <= '0;
      i_served_q   <= 1'b0;
      d_served_q   <= 1'b0;
      i_srv_addr_q <= '0;
      d_srv_addr_q <= '0;
      idata_q      <= 32'd0;
      drdata_q     <= 32'd0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_data_q    <= is_data_d;
      is_store_q   <= is_store_d;
      oor_q        <= oor_d;
      addr_q       <= addr_d;
      i_served_q   <= i_served_d;
      d_served_q   <= d_served_d;
      i_srv_addr_q <= i_srv_addr_d;
      d_srv_addr_q <= d_srv_addr_d;
      idata_q      <= idata_d;
      drdata_q     <= drdata_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

`ifdef MEM_RESP_RANGE_CHECK_EN
  logic err_q, err_d;
  assign err_d = (state_d == StDone) & oor_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Read data is bypassed in DONE so the core can use it in the cycle stall drops.
  assign idata     = (state_q == StDone && !is_data_q) ? rdata_eff : idata_q;
  assign drdata    = (state_q == StDone && is_data_q && !is_store_q) ? rdata_eff : drdata_q;
  assign stall     = ~rst & (((state_q == StIdle) & (i_new | d_new)) |
                             (state_q == StIssue) | (state_q == StWait));
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
